// File: rtl/trig_unit.sv
// Fixed-latency sine/cosine responder: integer-degree angle in, signed Q16.16 amplitude out.
// A quarter-wave table is folded across four quadrants, with a constant four-edge latency.
module trig_unit #(
  parameter int FUNC      = 0,
  parameter int FRAC_BITS = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [8:0]  value,
  output logic [31:0] amp_out,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_FOLD   = 3'd2,
    S_LOOKUP = 3'd3,
    S_OUTPUT = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  localparam int SHL = (FRAC_BITS > 16) ? (FRAC_BITS - 16) : 0;
  localparam int SHR = (FRAC_BITS < 16) ? (16 - FRAC_BITS) : 0;

  state_t      state_q, state_d;
  logic [8:0]  val_q, val_d;
  logic [8:0]  ang_q, ang_d;
  logic [6:0]  idx_q, idx_d;
  logic        neg_q, neg_d;
  logic [16:0] rom_q, rom_d;
  logic [31:0] amp_q, amp_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [31:0] mag_s;
  logic [7:0]  fold_s;

  // Cosine is sine shifted by +90 degrees; 10 bits keep the sum from overflowing.
  function automatic logic [8:0] reduce_angle(input logic [8:0] v);
    logic [9:0] a;
    a = {1'b0, v};
    if (a >= 10'd360) a = a - 10'd360;
    else              a = a;
    if (FUNC != 0) begin
      a = a + 10'd90;
      if (a >= 10'd360) a = a - 10'd360;
      else              a = a;
    end else begin
      a = a;
    end
    return a[8:0];
  endfunction

  function automatic logic [7:0] fold_angle(input logic [8:0] a);
    logic [8:0] d;
    logic       n;
    if (a <= 9'd90) begin
      d = a;            n = 1'b0;
    end else if (a <= 9'd180) begin
      d = 9'd180 - a;   n = 1'b0;
    end else if (a <= 9'd270) begin
      d = a - 9'd180;   n = 1'b1;
    end else begin
      d = 9'd360 - a;   n = 1'b1;
    end
    return {n, d[6:0]};
  endfunction

  // Entry k = round(sin(k deg) * 65536).
  function automatic logic [16:0] rom_entry(input logic [6:0] k);
    case (k)
      7'd0:  return 17'd0;     7'd1:  return 17'd1144;  7'd2:  return 17'd2287;  7'd3:  return 17'd3430;
      7'd4:  return 17'd4572;  7'd5:  return 17'd5712;  7'd6:  return 17'd6850;  7'd7:  return 17'd7987;
      7'd8:  return 17'd9121;  7'd9:  return 17'd10252; 7'd10: return 17'd11380; 7'd11: return 17'd12505;
      7'd12: return 17'd13626; 7'd13: return 17'd14742; 7'd14: return 17'd15855; 7'd15: return 17'd16962;
      7'd16: return 17'd18064; 7'd17: return 17'd19161; 7'd18: return 17'd20252; 7'd19: return 17'd21336;
      7'd20: return 17'd22415; 7'd21: return 17'd23486; 7'd22: return 17'd24550; 7'd23: return 17'd25607;
      7'd24: return 17'd26656; 7'd25: return 17'd27697; 7'd26: return 17'd28729; 7'd27: return 17'd29753;
      7'd28: return 17'd30767; 7'd29: return 17'd31772; 7'd30: return 17'd32768; 7'd31: return 17'd33754;
      7'd32: return 17'd34729; 7'd33: return 17'd35693; 7'd34: return 17'd36647; 7'd35: return 17'd37590;
      7'd36: return 17'd38521; 7'd37: return 17'd39441; 7'd38: return 17'd40348; 7'd39: return 17'd41243;
      7'd40: return 17'd42126; 7'd41: return 17'd42995; 7'd42: return 17'd43852; 7'd43: return 17'd44695;
      7'd44: return 17'd45525; 7'd45: return 17'd46341; 7'd46: return 17'd47143; 7'd47: return 17'd47930;
      7'd48: return 17'd48703; 7'd49: return 17'd49461; 7'd50: return 17'd50203; 7'd51: return 17'd50931;
      7'd52: return 17'd51643; 7'd53: return 17'd52339; 7'd54: return 17'd53020; 7'd55: return 17'd53684;
      7'd56: return 17'd54332; 7'd57: return 17'd54963; 7'd58: return 17'd55578; 7'd59: return 17'd56175;
      7'd60: return 17'd56756; 7'd61: return 17'd57319; 7'd62: return 17'd57865; 7'd63: return 17'd58393;
      7'd64: return 17'd58903; 7'd65: return 17'd59396; 7'd66: return 17'd59870; 7'd67: return 17'd60326;
      7'd68: return 17'd60764; 7'd69: return 17'd61183; 7'd70: return 17'd61584; 7'd71: return 17'd61966;
      7'd72: return 17'd62328; 7'd73: return 17'd62672; 7'd74: return 17'd62997; 7'd75: return 17'd63303;
      7'd76: return 17'd63589; 7'd77: return 17'd63856; 7'd78: return 17'd64104; 7'd79: return 17'd64332;
      7'd80: return 17'd64540; 7'd81: return 17'd64729; 7'd82: return 17'd64898; 7'd83: return 17'd65048;
      7'd84: return 17'd65177; 7'd85: return 17'd65287; 7'd86: return 17'd65376; 7'd87: return 17'd65446;
      7'd88: return 17'd65496; 7'd89: return 17'd65526; 7'd90: return 17'd65536;
      default: return 17'd0;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_REDUCE : S_IDLE;
      S_REDUCE: state_d = S_FOLD;
      S_FOLD:   state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_OUTPUT;
      S_OUTPUT: state_d = S_HOLD;
      S_HOLD:   state_d = start ? S_HOLD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mag_s  = ({15'd0, rom_q} << SHL) >> SHR;
  assign fold_s = fold_angle(ang_q);

  always_comb begin
    val_d  = val_q;
    ang_d  = ang_q;
    idx_d  = idx_q;
    neg_d  = neg_q;
    rom_d  = rom_q;
    amp_d  = amp_q;
    done_d = done_q;
    busy_d = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d  = value;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_REDUCE: ang_d = reduce_angle(val_q);
      S_FOLD: begin
        idx_d = fold_s[6:0];
        neg_d = fold_s[7];
      end
      S_LOOKUP: rom_d = rom_entry(idx_q);
      S_OUTPUT: begin
        amp_d  = neg_q ? (32'd0 - mag_s) : mag_s;
        done_d = 1'b1;
      end
      S_HOLD: begin
        if (!start) begin
          done_d = 1'b0;
          busy_d = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      val_q  <= 9'd0;
      ang_q  <= 9'd0;
      idx_q  <= 7'd0;
      neg_q  <= 1'b0;
      rom_q  <= 17'd0;
      amp_q  <= 32'd0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      ang_q  <= ang_d;
      idx_q  <= idx_d;
      neg_q  <= neg_d;
      rom_q  <= rom_d;
      amp_q  <= amp_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign amp_out = amp_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: doc/trig_unit.md
Name: trig_unit

Overview:
- Fixed-latency sine/cosine responder on the start/done handshake used by the orientation-vector stage.
- The vector stage is the initiator: it raises start with a 9-bit integer-degree angle and waits for done.
- This block is the responder: it returns a signed Q16.16 amplitude computed from a quarter-wave lookup table.
- One instance per trig term; the FUNC parameter selects sine or cosine.

Parameters:
- FUNC, 0, 0 = sine, 1 = cosine.
- FRAC_BITS, 16, fractional bits of amp_out; the table is scaled by 2^FRAC_BITS.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start  input  1  request. Level-held by the initiator until it sees done.
- value  input  9  angle in integer degrees, 0..511; values of 360 and above wrap.
- amp_out  output  32  signed Q16.16 result, two's complement.
- done  output  1  result valid. Held high while start remains high.
- busy  output  1  high from acceptance of a request until return to IDLE.

Behaviour:
- Reset (rst_in low, any time, asynchronous): state=IDLE, amp_out=0, done=0, busy=0. Any in-flight request is aborted and produces no done.
- States: IDLE -> REDUCE -> FOLD -> LOOKUP -> OUTPUT -> HOLD -> IDLE.
- IDLE: on a rising clk_in with start=1, latch value, set busy=1, go to REDUCE. With start=0, stay in IDLE.
- REDUCE: a = (value>=360) ? value-360 : value.
  - Cosine only: a = a+90, then subtract 360 if the sum is 360 or more.
  - Use a 10-bit intermediate so the sum cannot overflow.
- FOLD: derive table index idx (0..90) and sign neg from a:
  - 0..90: idx=a, neg=0.
  - 91..180: idx=180-a, neg=0.
  - 181..270: idx=a-180, neg=1.
  - 271..359: idx=360-a, neg=1.
- LOOKUP: registered read of the 91-entry ROM. Entry k = round(sin(k deg) * 65536), unsigned, 17 bits (entry 90 = 65536).
- OUTPUT: amp_out = neg ? -entry : entry, sign-extended to 32 bits. done<=1. Go to HOLD.
- Latency: done and amp_out are valid after the 4th rising edge following the accepting edge. The latency is constant for every angle.
- HOLD: done=1 and amp_out stable while start=1. On the first edge with start=0: done<=0, busy<=0, go to IDLE.
- amp_out keeps its last value in IDLE and changes only in OUTPUT.
- start dropped mid-computation: the computation still completes and done rises in OUTPUT. HOLD then sees start=0, so done is high for exactly one cycle.
- value changes after acceptance: ignored until the next request.
- Back-to-back requests: after done falls, start must be seen high in IDLE, so there is at least one idle cycle between requests.
- Several instances started on the same edge with the same FUNC finish on the same edge. The initiator's all-done condition depends on this.

Test Plan:
- FUNC=0, value=30, start held: done rises 4 edges after acceptance, amp_out=32'h00008000; done stays high until start drops, then falls on the next edge.
- FUNC=0 sweep: value=0 -> 0, 90 -> 32'h00010000, 180 -> 0, 270 -> 32'hFFFF0000, 45 -> 46341 (32'h0000B505), 315 -> -46341 (32'hFFFF4AFB).
- FUNC=1: value=0 -> 32'h00010000, 60 -> 32'h00008000, 180 -> 32'hFFFF0000, 359 -> 65526 (32'h0000FFF6; idx 89).
- Wrap: FUNC=0, value=390 -> same as 30 (32'h00008000); FUNC=1, value=450 -> 0; FUNC=1, value=511 -> cos(151) = -57319 (32'hFFFF2019).
- Handshake: start pulsed for one cycle with value=90 -> done high for exactly one cycle, 4 edges later, amp_out=32'h00010000. Changing value during REDUCE does not affect the result.
- Reset: assert rst_in low in LOOKUP (asynchronously, mid-cycle) -> amp_out=0, done=0, busy=0 immediately. After release, a new request with value=30 completes normally.
